uart_tx_arbiter: RTL

- Message-level round-robin arbiter that shares the single UART transmitter between up to NUM_REQ byte-stream sources (e.g. clock report, sensor 1, sensor 2).
- Sits between the requesters and the UART Tx handshake (start/data/busy/done).
- Grants one requester for a whole message, feeds its bytes one at a time and acknowledges each byte after the UART reports done.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-level round-robin arbiter sharing one UART Tx
// between NUM_REQ byte-stream sources. A requester is granted for a whole
// message. Each byte is started on the UART and acknowledged once the UART
// reports done.
// Optional per-byte watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NUM_REQ-1:0]   iReq,
  input  logic [8*NUM_REQ-1:0] iData,
  input  logic [NUM_REQ-1:0]   iLast,
  output logic [NUM_REQ-1:0]   oAck,
  output logic [NUM_REQ-1:0]   oGrant,
  output logic                 oArb_Busy,
  output logic                 oTx_Start,
  output logic [7:0]           oTx_Data,
  input  logic                 iTx_Busy,
  input  logic                 iTx_Done,
  output logic                 oErr
);

  localparam int          SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : gBadParams
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state;
  logic [SW-1:0]      sel;
  logic [SW-1:0]      ptr;
  logic [SW-1:0]      nextSel;
  logic [31:0]        ptrExt;
  logic               lastQ;
  logic               selReq;
  logic               selLast;
  logic [7:0]         selData;
  logic [NUM_REQ-1:0] selOneHot;

  assign ptrExt    = 32'(ptr);
  assign selOneHot = NUM_REQ'(1) << sel;

  // Round-robin pick. Descending scans let the lowest index win.
  // Indices above ptr are scanned last, so they take precedence over the
  // wrapped-around indices at or below ptr.
  always_comb begin
    nextSel = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (iReq[NR-1-j] && ((NR - 1 - j) <= ptrExt)) nextSel = SW'(NR - 1 - j);
    end
    for (int unsigned j = 0; j < NR; j++) begin
      if (iReq[NR-1-j] && ((NR - 1 - j) > ptrExt)) nextSel = SW'(NR - 1 - j);
    end
  end

  // Route the granted requester's request, byte and last flag.
  always_comb begin
    selReq  = 1'b0;
    selLast = 1'b0;
    selData = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (32'(sel) == i) begin
        selReq  = iReq[i];
        selLast = iLast[i];
        selData = iData[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] cnt;
`else
  assign oErr = 1'b0;
`endif

  // Arbitration / byte-handshake state machine with registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      sel       <= '0;
      ptr       <= SW'(NR - 1);
      lastQ     <= 1'b0;
      oGrant    <= '0;
      oAck      <= '0;
      oArb_Busy <= 1'b0;
      oTx_Start <= 1'b0;
      oTx_Data  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      oErr      <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      oAck      <= '0;
      oTx_Start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      oErr      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|iReq) begin
            sel       <= nextSel;
            oGrant    <= NUM_REQ'(1) << nextSel;
            oArb_Busy <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (!selReq) begin
            oGrant    <= '0;
            ptr       <= sel;
            oArb_Busy <= 1'b0;
            state     <= IDLE;
          end else if (!iTx_Busy) begin
            oTx_Data  <= selData;
            lastQ     <= selLast;
            oTx_Start <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (iTx_Done) begin
            oAck <= selOneHot;
            if (lastQ) begin
              oGrant    <= '0;
              ptr       <= sel;
              oArb_Busy <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= SEND;
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            oErr      <= 1'b1;
            oGrant    <= '0;
            ptr       <= sel;
            oArb_Busy <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
